// File: rtl/truth_table_scanner.sv
// Truth-table scanner: walks a 2-input function under test through all four
// minterms, captures its output per minterm and compares against an expected mask.
module truth_table_scanner #(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] expected,
    input  logic       f_in,
    output logic       a_out,
    output logic       b_out,
    output logic       busy,
    output logic       done,
    output logic [3:0] mask,
    output logic       match,
    output logic [1:0] first_bad
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    state_t     state, state_next;
    logic [1:0] idx, idx_next;
    logic [3:0] cnt, cnt_next;
    logic [3:0] mask_next;
    logic [3:0] exp_latch, exp_next;
    logic       a_next, b_next, busy_next, done_next, match_next;
    logic [1:0] first_bad_next;

    // Lowest minterm index where captured and expected tables disagree.
    function automatic logic [1:0] lowest_diff(input logic [3:0] m, input logic [3:0] e);
        logic [3:0] d;
        d = m ^ e;
        if (d[0])      return 2'd0;
        else if (d[1]) return 2'd1;
        else if (d[2]) return 2'd2;
        else if (d[3]) return 2'd3;
        else           return 2'd0;
    endfunction

    // Next-state, scan datapath and next-output computation.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        cnt_next   = cnt;
        mask_next  = mask;
        exp_next   = exp_latch;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SCAN;
                    exp_next   = expected;
                    mask_next  = 4'b0000;
                    idx_next   = 2'd0;
                    cnt_next   = 4'd0;
                end else begin
                    state_next = IDLE;
                end
            end
            SCAN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (cnt < SETTLE_C) begin
                    cnt_next = cnt + 4'd1;
                end else begin
                    mask_next[idx] = f_in;
                    cnt_next       = 4'd0;
                    if (idx == 2'd3) begin
                        state_next = DONE;
                    end else begin
                        idx_next = idx + 2'd1;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        busy_next      = (state_next == SCAN);
        done_next      = (state_next == DONE);
        a_next         = (state_next == SCAN) ? idx_next[1] : 1'b0;
        b_next         = (state_next == SCAN) ? idx_next[0] : 1'b0;
        match_next     = (mask_next == exp_next);
        first_bad_next = lowest_diff(mask_next, exp_next);
    end

    // State, datapath and output registers; outputs settle with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= 2'd0;
            cnt       <= 4'd0;
            mask      <= 4'b0000;
            exp_latch <= 4'b0000;
            a_out     <= 1'b0;
            b_out     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            match     <= 1'b1;
            first_bad <= 2'd0;
        end else begin
            state     <= state_next;
            idx       <= idx_next;
            cnt       <= cnt_next;
            mask      <= mask_next;
            exp_latch <= exp_next;
            a_out     <= a_next;
            b_out     <= b_next;
            busy      <= busy_next;
            done      <= done_next;
            match     <= match_next;
            first_bad <= first_bad_next;
        end
    end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed scoreboard bench for truth_table_scanner (SETTLE=1 and SETTLE=0 instances).
module tb_truth_table_scanner;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       start0 = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] expected = 4'b0000;
    logic       f_in, f_in0;
    logic       a_out, b_out, busy, done, match;
    logic       a0, b0, busy0, done0, match0;
    logic [3:0] mask, mask0;
    logic [1:0] first_bad, first_bad0;

    int  mode = 0;
    bit  use0 = 1'b0;
    int  total = 0;
    int  passed = 0;
    int  failed = 0;

    logic       s_a, s_b, s_busy, s_done, s_match;
    logic [3:0] s_mask;
    logic [1:0] s_fb;

    typedef struct {
        logic [3:0] mask;
        logic       match;
        logic [1:0] fb;
        int         edges;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    truth_table_scanner #(.SETTLE(1)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .expected(expected),
        .f_in(f_in), .a_out(a_out), .b_out(b_out), .busy(busy), .done(done),
        .mask(mask), .match(match), .first_bad(first_bad)
    );

    truth_table_scanner #(.SETTLE(0)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .abort(abort), .expected(expected),
        .f_in(f_in0), .a_out(a0), .b_out(b0), .busy(busy0), .done(done0),
        .mask(mask0), .match(match0), .first_bad(first_bad0)
    );

    function automatic logic fmodel(input int md, input logic a, input logic b);
        case (md)
            0:       return ~a & b;
            1:       return ~(a | b);
            2:       return a ^ b;
            3:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] fb_model(input logic [3:0] m, input logic [3:0] e);
        logic [1:0] fb;
        fb = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i] !== e[i]) fb = 2'(i);
        end
        return fb;
    endfunction

    always_comb f_in  = fmodel(mode, a_out, b_out);
    always_comb f_in0 = a0 | b0;

    always_comb begin
        if (use0) begin
            s_a = a0; s_b = b0; s_busy = busy0; s_done = done0;
            s_match = match0; s_mask = mask0; s_fb = first_bad0;
        end else begin
            s_a = a_out; s_b = b_out; s_busy = busy; s_done = done;
            s_match = match; s_mask = mask; s_fb = first_bad;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input bit sel0, input logic v);
        if (sel0) start0 = v;
        else      start  = v;
    endtask

    task automatic run_scan(input string tag, input bit sel0, input int md,
                            input logic [3:0] exp, input int restart_at, input int change_at,
                            input bit with_abort, output logic [15:0] ab_seq);
        exp_t e;
        bit   seen;
        int   lat_obs;
        int   extra_done;
        logic [1:0] mm;
        for (int m = 0; m < 4; m++) begin
            mm = 2'(m);
            e.mask[m] = sel0 ? (mm[1] | mm[0]) : fmodel(md, mm[1], mm[0]);
        end
        e.match = (e.mask == exp);
        e.fb    = fb_model(e.mask, exp);
        e.edges = sel0 ? 4 : 8;
        q.push_back(e);

        use0 = sel0;
        mode = md;
        @(negedge clk);
        expected = exp;
        abort    = with_abort;
        set_start(sel0, 1'b1);
        @(posedge clk); #1;
        set_start(sel0, 1'b0);
        abort  = 1'b0;
        ab_seq = 16'h0000;
        ab_seq[15:14] = {s_a, s_b};
        seen    = 1'b0;
        lat_obs = 0;
        for (int n = 1; n <= 40 && !seen; n++) begin
            if (n == change_at) expected = ~exp;
            if (n == restart_at) set_start(sel0, 1'b1);
            if (n == restart_at + 1) set_start(sel0, 1'b0);
            @(posedge clk); #1;
            if (n < 8) ab_seq[15 - 2*n -: 2] = {s_a, s_b};
            if (s_done) begin
                seen    = 1'b1;
                lat_obs = n;
            end
        end
        set_start(sel0, 1'b0);
        e = q.pop_front();
        check({tag, " done_seen"}, 32'(seen), 32'd1);
        check({tag, " latency"}, 32'(lat_obs), 32'(e.edges));
        check({tag, " busy_in_done"}, 32'(s_busy), 32'd0);
        check({tag, " mask"}, 32'(s_mask), 32'(e.mask));
        check({tag, " match"}, 32'(s_match), 32'(e.match));
        check({tag, " first_bad"}, 32'(s_fb), 32'(e.fb));
        extra_done = 0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            if (s_done) extra_done++;
        end
        check({tag, " single_done"}, 32'(extra_done), 32'd0);
        check({tag, " held_mask"}, 32'(s_mask), 32'(e.mask));
    endtask

    initial begin
        logic [15:0] ab;
        int dn;

        #1 reset = 1'b1;
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset ab", 32'({a_out, b_out}), 32'd0);
        check("reset mask", 32'(mask), 32'd0);
        check("reset match", 32'(match), 32'd1);
        check("reset first_bad", 32'(first_bad), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        reset = 1'b0;

        run_scan("golden", 1'b0, 0, 4'b0010, -1, -1, 1'b0, ab);
        run_scan("mismatch", 1'b0, 0, 4'b0100, -1, 2, 1'b0, ab);
        check("mismatch ab_seq", 32'(ab), 32'h05AF);
        run_scan("restart_ignored", 1'b0, 0, 4'b0010, 3, -1, 1'b0, ab);
        run_scan("xor_fb0", 1'b0, 2, 4'b1111, -1, -1, 1'b0, ab);
        run_scan("const1_fb3_startabort", 1'b0, 3, 4'b0111, -1, -1, 1'b1, ab);
        run_scan("zero_settle", 1'b1, 0, 4'b1110, -1, -1, 1'b0, ab);

        use0 = 1'b0;
        mode = 1;
        @(negedge clk);
        expected = 4'b0001;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort ab", 32'({a_out, b_out}), 32'd0);
        dn = 0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
        check("abort no_done", 32'(dn), 32'd0);
        check("abort mask", 32'(mask), 32'b0001);

        @(negedge clk);
        expected = 4'b0001;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_reset mask", 32'(mask), 32'b0001);
        check("pre_reset ab", 32'({a_out, b_out}), 32'b01);
        #2 reset = 1'b1;
        #1;
        check("async busy", 32'(busy), 32'd0);
        check("async ab", 32'({a_out, b_out}), 32'd0);
        check("async mask", 32'(mask), 32'd0);
        check("async done", 32'(done), 32'd0);
        check("async match", 32'(match), 32'd1);
        check("async first_bad", 32'(first_bad), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_scan("after_reset", 1'b0, 0, 4'b0010, -1, -1, 1'b0, ab);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/truth_table_scanner.md
TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

Interface
REQ-001 Parameter SETTLE, default 1: number of settle cycles between driving a minterm and sampling the function output, legal range 0..15.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a scan; sampled on the rising edge.
REQ-005 abort  input  1  cancel an in-progress scan.
REQ-006 expected  input  4  expected truth-table mask; bit m is the expected output for minterm m = {a,b}.
REQ-007 f_in  input  1  output of the 2-input function under test.
REQ-008 a_out  output  1  drives input a of the function under test (minterm bit 1).
REQ-009 b_out  output  1  drives input b of the function under test (minterm bit 0).
REQ-010 busy  output  1  high while a scan is in progress.
REQ-011 done  output  1  one-cycle pulse at the end of a completed scan.
REQ-012 mask  output  4  captured truth table; bit m holds f_in sampled for minterm m.
REQ-013 match  output  1  high when mask equals the latched expected value.
REQ-014 first_bad  output  2  lowest minterm index where mask and expected differ; 0 when match=1.

Function
REQ-015 The FSM SHALL have three states: IDLE, SCAN and DONE.
REQ-016 IDLE: a_out=b_out=0 and busy=0; start=1 at an edge latches expected, clears mask, sets idx=0 and cnt=0, and moves to SCAN.
REQ-017 SCAN: busy=1, a_out=idx[1], b_out=idx[0]; cnt increments every edge while cnt<SETTLE.
REQ-018 SCAN sampling: on the edge where cnt==SETTLE, mask[idx] is loaded with f_in and cnt resets to 0; if idx<3, idx increments, and if idx==3 the FSM moves to DONE.
REQ-019 Latency: each minterm occupies SETTLE+1 cycles, so the DONE state begins exactly 4*(SETTLE+1) edges after the edge that accepted start.
REQ-020 DONE lasts one cycle: done=1, busy=0, a_out=b_out=0, then the FSM returns unconditionally to IDLE.
REQ-021 match and first_bad are computed from mask and the latched expected value; they are valid from DONE onward and held until the next accepted start.
REQ-022 Later changes to the expected input after start acceptance do not affect the result.
REQ-023 start while in SCAN or DONE is ignored; it is neither queued nor restarted.
REQ-024 abort=1 at an edge in SCAN returns the FSM to IDLE with no done pulse; mask keeps its partially captured bits; abort is ignored in IDLE and DONE.
REQ-025 If start and abort are both 1 at the same edge in IDLE, start wins; abort only takes effect in SCAN.
REQ-026 mask bits not yet sampled in the current scan read 0.
REQ-027 idx is 2 bits and cnt is 4 bits; neither wraps during a legal scan.

Reset
REQ-028 reset=1 immediately, without waiting for a clock edge, forces: state=IDLE, idx=0, cnt=0, mask=0, expected latch=0, a_out=0, b_out=0, busy=0, done=0.
REQ-029 While reset is asserted, first_bad=0 and match=1, because mask equals the cleared expected latch.
REQ-030 reset asserted mid-scan aborts the scan and produces no done pulse; the first start after reset is released is accepted normally.

Verification
REQ-031 Golden scan: SETTLE=1, bench models f_in = ~a_out & b_out, expected=4'b0010, start pulsed -> done exactly 8 edges later, mask=0010, match=1, first_bad=0.
REQ-032 Mismatch: same model, expected=4'b0100 -> mask=0010, match=0, first_bad=1; a_out/b_out sequence is 00,00,01,01,10,10,11,11 over the 8 cycles.
REQ-033 Zero settle: SETTLE=0, f_in = a_out|b_out, expected=4'b1110 -> done 4 edges after start, match=1.
REQ-034 Start ignored: start re-pulsed at cycle 3 of a scan -> exactly one done pulse, at the original time; result unchanged.
REQ-035 Abort: abort pulsed on the 3rd edge of a SETTLE=1 scan -> busy drops next cycle, no done pulse, mask=000x with only bit 0 captured.
REQ-036 Async reset: reset raised between edges mid-scan -> busy, a_out, b_out and mask read 0 before the next edge; a subsequent start yields a full correct scan.
